chunked_adder: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a registered carry flop between chunks. It replaces the fixed 4-bit ripple adder wherever wide operands would make a single-cycle carry chain too long. Operands arrive and results leave over independent valid/ready handshakes, so the block drops into the datapath between a producer and a consumer.

---
 rtl/adder_pkg.sv | 16 +
 rtl/chunk_add.sv | 17 +
 rtl/chunked_adder.sv | 155 +++++++++++++++
 tb/tb_chunked_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int unsigned calc_nchunk(input int unsigned width,
                                              input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice with carry-in and carry-out.
module chunk_add #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s_c,
  output logic             co_c
);

  logic [CHUNK:0] full_c;

  assign full_c      = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign {co_c, s_c} = full_c;

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready on both sides.
// Optional subtract mode (sub port) is built when SUB_EN is defined.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  // Reject configurations that do not split evenly into chunks.
  if (CHUNK == 0) begin : g_bad_chunk
    $error("chunked_adder: CHUNK must be positive");
  end else if ((WIDTH == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
    $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t state_q, state_d;

  logic [KW-1:0]                 k_q, k_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  a_q, a_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  b_q, b_d;
  logic [NCHUNK-1:0][CHUNK-1:0]  acc_q, acc_d;
  logic                          carry_q, carry_d;
  logic [WIDTH-1:0]              sum_d;
  logic                          cout_d;
  logic                          ovf_d;
  logic                          in_ready_d;
  logic                          out_valid_d;

  logic [WIDTH-1:0]              b_eff_c;
  logic                          carry_in_c;
  logic [CHUNK-1:0]              cs_c;
  logic                          cco_c;

  // Operand conditioning at the input port; subtract is a + ~b + 1.
`ifdef SUB_EN
  assign b_eff_c    = sub ? ~b : b;
  assign carry_in_c = sub | cin;
`else
  assign b_eff_c    = b;
  assign carry_in_c = cin;
`endif

  // Single slice adder, steered over chunk index k.
  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .a    (a_q[k_q]),
    .b    (b_q[k_q]),
    .ci   (carry_q),
    .s_c  (cs_c),
    .co_c (cco_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    sum_d       = sum;
    cout_d      = cout;
    ovf_d       = ovf;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b_eff_c;
          carry_d = carry_in_c;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[k_q] = cs_c;
        carry_d    = cco_c;
        k_d        = k_q + KW'(1);
        if (k_q == KLAST) begin
          k_d     = '0;
          sum_d   = acc_d;
          cout_d  = cco_c;
          ovf_d   = (a_q[NCHUNK-1][CHUNK-1] == b_q[NCHUNK-1][CHUNK-1]) &&
                    (acc_d[NCHUNK-1][CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      sum       <= sum_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed self-checking bench for chunked_adder (16/4 and degenerate 8/8).
module tb_chunked_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
`ifdef SUB_EN
  logic        sub;
  logic        sub8;
`endif

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int checks = 0;
  int errors = 0;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
`ifdef SUB_EN
    .sub       (sub8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Handshake one operation into the 16-bit DUT; returns cycles to out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts, output int lat);
    int guard;
    lat   = 0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0");
      return;
    end
    a = ta; b = tb_v; cin = tc;
`ifdef SUB_EN
    sub = ts;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = ~tc ^ ts;
`ifdef SUB_EN
    sub = ~ts;
`endif
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout: out_valid stuck at 0");
    end
  endtask

  task automatic run_table(input vec_t v, input int idx);
    int lat;
    run_op(v.a, v.b, v.cin, v.sub, lat);
    check($sformatf("v%0d_sum", idx), 32'(sum), 32'(v.s));
    check($sformatf("v%0d_cout", idx), 32'(cout), 32'(v.co));
    check($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.ov));
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'd4);
    @(posedge clk);
    @(negedge clk);
  endtask

  // out_valid and in_ready must never be high together.
  always @(negedge clk) begin
    if (!rst && out_valid && in_ready) begin
      errors++;
      $display("FAIL valid_ready_overlap: out_valid=1 in_ready=1");
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
`ifdef SUB_EN
    vec_t svecs[3];
`endif
    int lat;
    int rises[16];
    int nrise;
    int cyc;
    logic prev_ov;
    logic [31:0] st;

    vecs[0] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h000A, 16'h0005, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef SUB_EN
    svecs[0] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    svecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    svecs[2] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    sub  = 1'b0;
    sub8 = 1'b0;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {13'd0, cout, ovf, 1'b0, sum}, 32'd0);
    check("rst_in_ready8", 32'(in_ready8), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_table(vecs[i], i);
`ifdef SUB_EN
    foreach (svecs[i]) run_table(svecs[i], 100 + i);
`endif

    // Backpressure: DONE holds with stable outputs.
    out_ready = 1'b0;
    run_op(16'h000A, 16'h0005, 1'b1, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      st = {12'd0, out_valid, in_ready, cout, ovf, sum};
      check($sformatf("bp_hold%0d", i), st, {12'd0, 4'b1000, 16'h0010});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset two cycles into an operation discards it.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outputs", {12'd0, out_valid, in_ready, cout, ovf, sum}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    st = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      st = st | 32'(out_valid);
    end
    check("midrst_no_result", st, 32'd0);
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    check("midrst_fresh_sum", 32'(sum), 32'h2345);
    check("midrst_fresh_lat", 32'(lat), 32'd4);
    @(posedge clk);
    @(negedge clk);

    // Back-to-back with in_valid held high.
    a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
    nrise = 0; prev_ov = out_valid; cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid && !prev_ov && nrise < 16) begin
        rises[nrise] = cyc;
        nrise++;
        check($sformatf("b2b_sum%0d", nrise), 32'(sum), 32'h0303);
      end
      prev_ov = out_valid;
    end
    in_valid = 1'b0;
    check("b2b_count_ge5", 32'(nrise >= 5), 32'd1);
    for (int i = 1; i < nrise; i++) begin
      check($sformatf("b2b_interval%0d", i), 32'(rises[i] - rises[i-1]), 32'd6);
    end
    repeat (8) @(negedge clk);

    // Degenerate WIDTH == CHUNK: one-cycle latency.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; in_valid8 = 1'b1;
    check("w8_ready", 32'(in_ready8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    check("w8_not_early", 32'(out_valid8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("w8_result", {20'd0, out_valid8, cout8, ovf8, 1'b0, sum8}, {20'd0, 4'b1110, 8'h00});
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w8_result2", {20'd0, out_valid8, cout8, ovf8, 1'b0, sum8}, {20'd0, 4'b1010, 8'h80});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
